// File: rtl/dtack_generator_if.sv
// rtl/dtack_generator_if.sv - bus-cycle signals between the address decoder, CPU strobes and the DTACK# stage
interface dtack_generator_if;
    logic as_n;
    logic ram_sel_n;
    logic rom_sel_n;
    logic pit_sel_n;
    logic uart_sel_n;
    logic vdp_sel_n;
    logic vdp_wait_n;
    logic dtack_n;
    logic busy;
    logic decode_err;

    modport master (
        output as_n, ram_sel_n, rom_sel_n, pit_sel_n, uart_sel_n, vdp_sel_n, vdp_wait_n,
        input  dtack_n, busy, decode_err
    );

    modport slave (
        input  as_n, ram_sel_n, rom_sel_n, pit_sel_n, uart_sel_n, vdp_sel_n, vdp_wait_n,
        output dtack_n, busy, decode_err
    );
endinterface

// File: rtl/dtack_generator.sv
// rtl/dtack_generator.sv - registered DTACK# with per-region wait states, VDP wait stretching and abort
module dtack_generator #(
    parameter int unsigned RAM_WS  = 0,
    parameter int unsigned ROM_WS  = 2,
    parameter int unsigned PIT_WS  = 3,
    parameter int unsigned UART_WS = 3,
    parameter int unsigned VDP_WS  = 1,
    parameter int unsigned CNT_W   = 4
) (
    input  logic               clk,
    input  logic               reset,
    dtack_generator_if.slave   bus
);

    typedef logic [CNT_W-1:0] cnt_t;
    typedef enum logic [1:0] {IDLE, COUNT, VWAIT, ACK} state_t;

    state_t state_q, state_d;
    cnt_t   cnt_q, cnt_d;
    logic   vdp_q, vdp_d;
    logic   dtack_n_q, dtack_n_d;
    logic   busy_q, busy_d;
    logic   decode_err_q, decode_err_d;

    logic [4:0] sel_low;
    logic       sel_multi;
    logic       pick_vdp;
    cnt_t       pick_ws;

    assign sel_low   = {~bus.ram_sel_n, ~bus.rom_sel_n, ~bus.pit_sel_n,
                        ~bus.uart_sel_n, ~bus.vdp_sel_n};
    assign sel_multi = (sel_low & (sel_low - 5'd1)) != 5'd0;

    // Region priority RAM > ROM > PIT > UART > VDP decides the wait count.
    always_comb begin
        pick_vdp = 1'b0;
        pick_ws  = cnt_t'(VDP_WS);
        if (sel_low[4])      pick_ws = cnt_t'(RAM_WS);
        else if (sel_low[3]) pick_ws = cnt_t'(ROM_WS);
        else if (sel_low[2]) pick_ws = cnt_t'(PIT_WS);
        else if (sel_low[1]) pick_ws = cnt_t'(UART_WS);
        else                 pick_vdp = 1'b1;
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        vdp_d        = vdp_q;
        decode_err_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!bus.as_n && (sel_low != 5'd0)) begin
                    decode_err_d = sel_multi;
                    vdp_d        = pick_vdp;
                    cnt_d        = pick_ws;
                    if (pick_ws != cnt_t'(0))          state_d = COUNT;
                    else if (!pick_vdp || bus.vdp_wait_n) state_d = ACK;
                    else                                  state_d = VWAIT;
                end
            end
            COUNT: begin
                if (bus.as_n) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                    if (cnt_q == cnt_t'(1))
                        state_d = (!vdp_q || bus.vdp_wait_n) ? ACK : VWAIT;
                end
            end
            VWAIT: begin
                if (bus.as_n)            state_d = IDLE;
                else if (bus.vdp_wait_n) state_d = ACK;
            end
            ACK: begin
                if (bus.as_n) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        dtack_n_d = (state_d != ACK);
        busy_d    = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            vdp_q        <= 1'b0;
            dtack_n_q    <= 1'b1;
            busy_q       <= 1'b0;
            decode_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            vdp_q        <= vdp_d;
            dtack_n_q    <= dtack_n_d;
            busy_q       <= busy_d;
            decode_err_q <= decode_err_d;
        end
    end

    assign bus.dtack_n    = dtack_n_q;
    assign bus.busy       = busy_q;
    assign bus.decode_err = decode_err_q;

endmodule

// File: tb/tb_dtack_generator.sv
// tb/tb_dtack_generator.sv - directed scoreboard bench for dtack_generator
module tb_dtack_generator;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    dtack_generator_if bus_if ();

    dtack_generator dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    typedef struct {
        logic  dtack_n;
        logic  busy;
        logic  err;
        string name;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    // select vector order: {ram, rom, pit, uart, vdp}, active low
    localparam logic [4:0] NONE = 5'b11111;
    localparam logic [4:0] RAM  = 5'b01111;
    localparam logic [4:0] ROM  = 5'b10111;
    localparam logic [4:0] PIT  = 5'b11011;
    localparam logic [4:0] UART = 5'b11101;
    localparam logic [4:0] VDP  = 5'b11110;

    task automatic cyc(input logic as, input logic [4:0] sel, input logic wt,
                       input logic e_dt, input logic e_busy, input logic e_err,
                       input string name);
        exp_t e;
        @(negedge clk);
        bus_if.as_n       = as;
        bus_if.ram_sel_n  = sel[4];
        bus_if.rom_sel_n  = sel[3];
        bus_if.pit_sel_n  = sel[2];
        bus_if.uart_sel_n = sel[1];
        bus_if.vdp_sel_n  = sel[0];
        bus_if.vdp_wait_n = wt;
        e.dtack_n = e_dt;
        e.busy    = e_busy;
        e.err     = e_err;
        e.name    = name;
        sb.push_back(e);
    endtask

    task automatic check_now(input logic e_dt, input logic e_busy, input logic e_err,
                             input string name);
        vectors++;
        if ({bus_if.dtack_n, bus_if.busy, bus_if.decode_err} !== {e_dt, e_busy, e_err}) begin
            miscompares++;
            $display("FAIL %s: got dtack_n/busy/decode_err=%b%b%b expected %b%b%b", name,
                     bus_if.dtack_n, bus_if.busy, bus_if.decode_err, e_dt, e_busy, e_err);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check_now(e.dtack_n, e.busy, e.err, e.name);
            end
        end
    end

    initial begin : stimulus
        int guard;
        bus_if.as_n = 1'b1;
        bus_if.ram_sel_n = 1'b1; bus_if.rom_sel_n = 1'b1; bus_if.pit_sel_n = 1'b1;
        bus_if.uart_sel_n = 1'b1; bus_if.vdp_sel_n = 1'b1; bus_if.vdp_wait_n = 1'b1;
        repeat (2) @(negedge clk);
        check_now(1'b1, 1'b0, 1'b0, "reset_state");
        reset = 1'b0;
        cyc(1, NONE, 1, 1, 0, 0, "idle");

        // RAM, zero waits
        cyc(0, RAM, 1, 0, 1, 0, "ram_e1");
        cyc(0, RAM, 1, 0, 1, 0, "ram_e2");
        cyc(0, RAM, 1, 0, 1, 0, "ram_e3");
        cyc(1, NONE, 1, 1, 0, 0, "ram_e4_release");

        // ROM, two waits
        cyc(0, ROM, 1, 1, 1, 0, "rom_e1");
        cyc(0, ROM, 1, 1, 1, 0, "rom_e2");
        cyc(0, ROM, 1, 0, 1, 0, "rom_e3_ack");
        cyc(0, ROM, 1, 0, 1, 0, "rom_e4_hold");
        cyc(1, NONE, 1, 1, 0, 0, "rom_release");

        // VDP stretched by vdp_wait_n until edge 6
        cyc(0, VDP, 0, 1, 1, 0, "vdp_e1");
        for (int i = 2; i <= 5; i++) cyc(0, VDP, 0, 1, 1, 0, "vdp_wait");
        cyc(0, VDP, 1, 0, 1, 0, "vdp_e6_ack");
        cyc(1, NONE, 1, 1, 0, 0, "vdp_release");

        // VDP with no wait requested acks at edge N+VDP_WS
        cyc(0, VDP, 1, 1, 1, 0, "vdp_fast_e1");
        cyc(0, VDP, 1, 0, 1, 0, "vdp_fast_e2");
        cyc(1, NONE, 1, 1, 0, 0, "vdp_fast_release");

        // unmapped / IACK
        for (int i = 0; i < 20; i++) cyc(0, NONE, 1, 1, 0, 0, "unmapped");
        cyc(1, NONE, 1, 1, 0, 0, "unmapped_end");

        // UART aborted
        cyc(0, UART, 1, 1, 1, 0, "uart_e1");
        cyc(1, NONE, 1, 1, 0, 0, "uart_abort");
        cyc(1, NONE, 1, 1, 0, 0, "uart_after");

        // decode conflict, RAM wins
        cyc(0, RAM & UART, 1, 0, 1, 1, "conflict_e1");
        cyc(0, RAM & UART, 1, 0, 1, 0, "conflict_e2");
        cyc(1, NONE, 1, 1, 0, 0, "conflict_release");

        // PIT, select changes mid-cycle and must be ignored
        cyc(0, PIT, 1, 1, 1, 0, "pit_e1");
        cyc(0, RAM, 1, 1, 1, 0, "pit_e2_selchg");
        cyc(0, RAM, 1, 1, 1, 0, "pit_e3");
        cyc(0, RAM, 1, 0, 1, 0, "pit_e4_ack");
        cyc(1, NONE, 1, 1, 0, 0, "pit_release");

        // back-to-back RAM cycles
        cyc(0, RAM, 1, 0, 1, 0, "b2b_a");
        cyc(1, NONE, 1, 1, 0, 0, "b2b_gap");
        cyc(0, RAM, 1, 0, 1, 0, "b2b_b");
        cyc(1, NONE, 1, 1, 0, 0, "b2b_end");

        // async reset in ACK
        cyc(0, RAM, 1, 0, 1, 0, "pre_reset_ack");
        @(negedge clk);
        #2 reset = 1'b1;
        #1 check_now(1'b1, 1'b0, 1'b0, "async_reset");
        @(negedge clk);
        bus_if.as_n = 1'b1;
        bus_if.ram_sel_n = 1'b1;
        reset = 1'b0;
        cyc(0, RAM, 1, 0, 1, 0, "post_reset_ram");
        cyc(1, NONE, 1, 1, 0, 0, "post_reset_release");

        guard = 0;
        while (sb.size() > 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (sb.size() > 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
